// File: rtl/led_peripheral_blink.sv
// Memory-mapped LED register with per-LED blink engine and toggle writes.
// Define LED_PWM_EN to add global PWM dimming via the DUTY register at 0x14.
module led_peripheral_blink #(
  parameter int unsigned NUM_LEDS = 8,
  parameter int unsigned PER_W    = 24,
  parameter int unsigned PWM_W    = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                rd_en_i,
  input  logic                wr_en_i,
  input  logic [31:0]         addr_i,
  input  logic [31:0]         data_i,
  output logic [31:0]         data_o,
  output logic [NUM_LEDS-1:0] leds_o
);

  localparam logic [4:0] AddrLedWr  = 5'h00;
  localparam logic [4:0] AddrLedRd  = 5'h04;
  localparam logic [4:0] AddrMask   = 5'h08;
  localparam logic [4:0] AddrPeriod = 5'h0C;
  localparam logic [4:0] AddrToggle = 5'h10;
`ifdef LED_PWM_EN
  localparam logic [4:0] AddrDuty   = 5'h14;
`endif

  logic [NUM_LEDS-1:0] led_reg_q, led_reg_d;
  logic [NUM_LEDS-1:0] mask_q, mask_d;
  logic [PER_W-1:0]    per_q, per_d;
  logic [PER_W-1:0]    cnt_q, cnt_d;
  logic                phase_q, phase_d;
  logic [NUM_LEDS-1:0] leds_q, leds_d;
  logic [NUM_LEDS-1:0] base;
  logic [4:0]          offset;
`ifdef LED_PWM_EN
  logic [PWM_W-1:0]    duty_q, duty_d;
  logic [PWM_W-1:0]    pwm_cnt_q;
`endif

  // Only the low five address bits are decoded; the rest of the bus is ignored.
  logic unused_bits;
  assign unused_bits = ^{addr_i[31:5], data_i};

  assign offset = addr_i[4:0];

  always_comb begin
    led_reg_d = led_reg_q;
    mask_d    = mask_q;
    per_d     = per_q;
    cnt_d     = cnt_q;
    phase_d   = phase_q;
`ifdef LED_PWM_EN
    duty_d    = duty_q;
`endif
    if (per_q == '0) begin
      cnt_d   = '0;
      phase_d = 1'b0;
    end else if (cnt_q == per_q - PER_W'(1)) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + PER_W'(1);
    end
    // Bus writes are applied last so a PERIOD write overrides a same-cycle wrap.
    if (wr_en_i) begin
      case (offset)
        AddrLedWr:  led_reg_d = data_i[NUM_LEDS-1:0];
        AddrMask:   mask_d    = data_i[NUM_LEDS-1:0];
        AddrPeriod: begin
          per_d   = data_i[PER_W-1:0];
          cnt_d   = '0;
          phase_d = 1'b0;
        end
        AddrToggle: led_reg_d = led_reg_q ^ data_i[NUM_LEDS-1:0];
`ifdef LED_PWM_EN
        AddrDuty:   duty_d    = data_i[PWM_W-1:0];
`endif
        default: ;
      endcase
    end
  end

  assign base = led_reg_q & ~(mask_q & {NUM_LEDS{phase_q}});

`ifdef LED_PWM_EN
  assign leds_d = base & {NUM_LEDS{pwm_cnt_q < duty_q}};
`else
  assign leds_d = base;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_reg_q <= '0;
      mask_q    <= '0;
      per_q     <= '0;
      cnt_q     <= '0;
      phase_q   <= 1'b0;
      leds_q    <= '0;
    end else begin
      led_reg_q <= led_reg_d;
      mask_q    <= mask_d;
      per_q     <= per_d;
      cnt_q     <= cnt_d;
      phase_q   <= phase_d;
      leds_q    <= leds_d;
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q    <= '0;
      pwm_cnt_q <= '0;
    end else begin
      duty_q    <= duty_d;
      pwm_cnt_q <= pwm_cnt_q + PWM_W'(1);
    end
  end
`endif

  assign leds_o = leds_q;

  always_comb begin
    data_o = 32'h0;
    if (rd_en_i) begin
      case (offset)
        AddrLedRd:  data_o = 32'(led_reg_q);
        AddrMask:   data_o = 32'(mask_q);
        AddrPeriod: data_o = 32'(per_q);
`ifdef LED_PWM_EN
        AddrDuty:   data_o = 32'(duty_q);
`endif
        default:    data_o = 32'h0;
      endcase
    end
  end

endmodule

// File: tb/tb_led_peripheral_blink.sv
// Scoreboard bench for led_peripheral_blink: expected read data and LED values
// are queued as stimulus is driven and popped when the DUT output is sampled.
module tb_led_peripheral_blink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rd_en = 1'b0;
  logic        wr_en = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [31:0] rdata;
  logic [7:0]  leds;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] rd_q[$];
  logic [31:0] led_q[$];

  led_peripheral_blink #(
    .NUM_LEDS(8),
    .PER_W   (24),
    .PWM_W   (8)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .rd_en_i(rd_en),
    .wr_en_i(wr_en),
    .addr_i (addr),
    .data_i (wdata),
    .data_o (rdata),
    .leds_o (leds)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en = 1'b1;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic pop_read(input string tag);
    logic [31:0] exp;
    if (rd_q.size() == 0) begin
      check({tag, " (empty queue)"}, 32'h1, 32'h0);
    end else begin
      exp = rd_q.pop_front();
      check(tag, rdata, exp);
    end
  endtask

  task automatic pop_led(input string tag);
    logic [31:0] exp;
    if (led_q.size() == 0) begin
      check({tag, " (empty queue)"}, 32'h1, 32'h0);
    end else begin
      exp = led_q.pop_front();
      check(tag, {24'h0, leds}, exp);
    end
  endtask

  // Combinational read: drive, settle, compare against the queued value.
  task automatic bus_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    rd_q.push_back(exp);
    rd_en = 1'b1;
    addr  = a;
    #1;
    pop_read(tag);
    rd_en = 1'b0;
  endtask

  task automatic led_after_edge(input string tag, input logic [7:0] exp);
    led_q.push_back({24'h0, exp});
    @(posedge clk);
    #1;
    pop_led(tag);
  endtask

  initial begin
    int hi_cnt;
    int lo_cnt;

    // Reset state
    rd_en = 1'b1;
    addr  = 32'h4;
    #2;
    rd_q.push_back(32'h0);
    pop_read("reset_data");
    led_q.push_back(32'h0);
    pop_led("reset_leds");
    rd_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write / readback and output lag
    bus_write(32'h00, 32'hFFFF_FFA5);
    bus_read("led_rd_a5", 32'h04, 32'hA5);
    bus_read("led_wr_reads0", 32'h00, 32'h0);
`ifndef LED_PWM_EN
    led_q.push_back(32'h0);
    pop_led("leds_lag");
    led_after_edge("leds_a5", 8'hA5);
`endif

    // Toggle writes
    bus_write(32'h00, 32'hFF);
    bus_write(32'h10, 32'h0F);
    bus_read("toggle_f0", 32'h04, 32'hF0);
    bus_write(32'h10, 32'hF0);
    bus_read("toggle_00", 32'h04, 32'h00);
    bus_read("toggle_reads0", 32'h10, 32'h0);

    // Unmapped offsets
    bus_read("rd_18", 32'h18, 32'h0);
    bus_read("rd_1c", 32'h1C, 32'h0);
    bus_write(32'h18, 32'hFFFF_FFFF);
    bus_write(32'h1C, 32'hFFFF_FFFF);
    bus_read("unm_led", 32'h04, 32'h0);
    bus_read("unm_mask", 32'h08, 32'h0);
    bus_read("unm_per", 32'h0C, 32'h0);
    bus_write(32'hFFFF_FF04, 32'hFF);
    bus_read("led_rd_ro", 32'h04, 32'h0);
`ifndef LED_PWM_EN
    bus_write(32'h14, 32'h55);
    bus_read("duty_unmapped", 32'h14, 32'h0);
`endif

    // Simultaneous read and write: pre-edge value visible until the edge
    @(negedge clk);
    rd_en = 1'b1;
    wr_en = 1'b1;
    addr  = 32'h08;
    wdata = 32'h3C;
    #1;
    rd_q.push_back(32'h0);
    pop_read("rdwr_pre");
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_q.push_back(32'h3C);
    pop_read("rdwr_post");
    rd_en = 1'b0;

`ifndef LED_PWM_EN
    // Blink engine: half-period of 4 cycles on LED0
    bus_write(32'h00, 32'hFF);
    bus_write(32'h08, 32'h01);
    bus_write(32'h0C, 32'h4);
    bus_read("period_rd", 32'h0C, 32'h4);
    for (int k = 1; k <= 16; k++) begin
      led_after_edge($sformatf("blink_%0d", k), (((k - 1) / 4) % 2 == 1) ? 8'hFE : 8'hFF);
    end
    bus_write(32'h0C, 32'h0);
    for (int k = 0; k < 8; k++) begin
      led_after_edge($sformatf("blink_off_%0d", k), 8'hFF);
    end
    bus_read("period_zero", 32'h0C, 32'h0);
`else
    // PWM dimming: 64 of every 256 cycles lit
    bus_write(32'h00, 32'hFF);
    bus_write(32'h08, 32'h00);
    bus_write(32'h14, 32'd64);
    bus_read("duty_rd", 32'h14, 32'd64);
    @(posedge clk);
    hi_cnt = 0;
    lo_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      if (leds == 8'hFF) hi_cnt++;
      if (leds == 8'h00) lo_cnt++;
    end
    check("pwm_hi", hi_cnt, 64);
    check("pwm_lo", lo_cnt, 192);
    bus_write(32'h14, 32'd0);
    @(posedge clk);
    hi_cnt = 0;
    for (int k = 0; k < 256; k++) begin
      @(posedge clk);
      #1;
      if (leds != 8'h00) hi_cnt++;
    end
    check("pwm_dark", hi_cnt, 0);
`endif

    // Asynchronous reset mid-operation
    bus_write(32'h00, 32'h5A);
    bus_write(32'h08, 32'hF0);
    bus_write(32'h0C, 32'h2);
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    led_q.push_back(32'h0);
    pop_led("async_rst_leds");
    bus_read("async_rst_led", 32'h04, 32'h0);
    bus_read("async_rst_mask", 32'h08, 32'h0);
    bus_read("async_rst_per", 32'h0C, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    led_after_edge("post_rst_leds", 8'h00);

    if (rd_q.size() != 0 || led_q.size() != 0) check("queues_drained", 32'h1, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
